// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_apb_decoder.sv
// Combinational slave decode of the address bits at and above the slave-index field.
module ahb_apb_decoder #(
    parameter int FIELD_W    = 20,
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [FIELD_W-1:0]    field_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  unmapped_o
);

    logic hi_nz;

    assign idx_o = field_i[IDX_W-1:0];

    // Any set bit above the index field lands outside the APB window.
    generate
        if (FIELD_W > IDX_W) begin : g_hi
            assign hi_nz = |field_i[FIELD_W-1:IDX_W];
        end else begin : g_nohi
            assign hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        unmapped_o = hi_nz || ({1'b0, idx_o} >= (IDX_W+1)'(NUM_SLAVES));
        sel_o      = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_o[i] = !unmapped_o && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite to multi-slave APB bridge with wait states, slave error, decode error and timeout.
module ahb_apb_bridge_param
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_LSB    = 12,
    parameter int TIMEOUT    = 0
) (
    input  logic                         Hclk,
    input  logic                         Hreset,
    input  logic                         Hwrite,
    input  logic                         Hreadyin,
    input  logic [1:0]                   Htrans,
    input  logic [ADDR_W-1:0]            Haddr,
    input  logic [DATA_W-1:0]            Hwdata,
    output logic [DATA_W-1:0]            Hrdata,
    output logic                         Hresp,
    output logic                         Hreadyout,
    output logic [ADDR_W-1:0]            Paddr,
    output logic [DATA_W-1:0]            Pwdata,
    output logic                         Pwrite,
    output logic [NUM_SLAVES-1:0]        Pselx,
    output logic                         Penable,
    input  logic [NUM_SLAVES*DATA_W-1:0] Prdata,
    input  logic [NUM_SLAVES-1:0]        Pready,
    input  logic [NUM_SLAVES-1:0]        Pslverr
);

    localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int FIELD_W = ADDR_W - SLV_LSB;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    bridge_state_t         state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     hrdata_q;
    logic                  hresp_q;
    logic                  hready_q;
    logic [ADDR_W-1:0]     paddr_q;
    logic [DATA_W-1:0]     pwdata_q;
    logic                  pwrite_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;

    htrans_t               htrans_s;
    logic                  xfer_vld;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_unmapped;

    assign htrans_s = htrans_t'(Htrans);
    assign xfer_vld = Hreadyin && ((htrans_s == HTRANS_NONSEQ) || (htrans_s == HTRANS_SEQ));

    ahb_apb_decoder #(
        .FIELD_W   (FIELD_W),
        .NUM_SLAVES(NUM_SLAVES),
        .IDX_W     (IDX_W)
    ) u_dec (
        .field_i   (Haddr[ADDR_W-1:SLV_LSB]),
        .idx_o     (dec_idx),
        .sel_o     (dec_sel),
        .unmapped_o(dec_unmapped)
    );

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            hrdata_q  <= '0;
            hresp_q   <= HRESP_OKAY;
            hready_q  <= 1'b1;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                    state_q  <= ST_IDLE;
                    if (xfer_vld) begin
                        hready_q <= 1'b0;
                        if (dec_unmapped) begin
                            hresp_q <= HRESP_ERROR;
                            state_q <= ST_ERR1;
                        end else begin
                            idx_q    <= dec_idx;
                            sel_q    <= dec_sel;
                            paddr_q  <= Haddr;
                            pwrite_q <= Hwrite;
                            if (Hwrite) begin
                                state_q <= ST_WDATA;
                            end else begin
                                psel_q  <= dec_sel;
                                state_q <= ST_SETUP;
                            end
                        end
                    end
                end
                // Write data arrives one cycle after the address phase.
                ST_WDATA: begin
                    pwdata_q <= Hwdata;
                    psel_q   <= sel_q;
                    state_q  <= ST_SETUP;
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (Pready[idx_q]) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        if (Pslverr[idx_q]) begin
                            hresp_q <= HRESP_ERROR;
                            state_q <= ST_ERR1;
                        end else begin
                            hready_q <= 1'b1;
                            state_q  <= ST_DONE;
                            if (!pwrite_q) begin
                                hrdata_q <= Prdata[idx_q*DATA_W +: DATA_W];
                            end
                        end
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        // Abandon a slave that never answers; the master sees an ERROR.
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        hresp_q   <= HRESP_ERROR;
                        state_q   <= ST_ERR1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERR1: begin
                    hresp_q  <= HRESP_ERROR;
                    hready_q <= 1'b1;
                    state_q  <= ST_ERR2;
                end
                ST_ERR2: begin
                    hresp_q  <= HRESP_OKAY;
                    hready_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Hrdata    = hrdata_q;
    assign Hresp     = hresp_q;
    assign Hreadyout = hready_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Pwrite    = pwrite_q;
    assign Pselx     = psel_q;
    assign Penable   = penable_q;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Bench for ahb_apb_bridge_param: AHB master and APB slave driven from tasks, checked against a transfer-level model.
module tb_ahb_apb_bridge_param;

    localparam int TMO = 8;

    logic         Hclk = 1'b0;
    logic         Hreset;
    logic         Hwrite;
    logic         Hreadyin;
    logic [1:0]   Htrans;
    logic [31:0]  Haddr;
    logic [31:0]  Hwdata;
    logic [31:0]  Hrdata;
    logic         Hresp;
    logic         Hreadyout;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;
    logic         Pwrite;
    logic [3:0]   Pselx;
    logic         Penable;
    logic [127:0] Prdata;
    logic [3:0]   Pready;
    logic [3:0]   Pslverr;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hrdata;

    ahb_apb_bridge_param #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SLV_LSB(12), .TIMEOUT(TMO)
    ) dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata),
        .Hresp(Hresp), .Hreadyout(Hreadyout), .Paddr(Paddr), .Pwdata(Pwdata),
        .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 Hclk = ~Hclk;

    // Runs one AHB transfer with a cooperating APB slave; returns what was observed.
    task automatic run_xfer(
        input  bit          b2b,
        input  bit          wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          nwait,
        input  bit          serr,
        input  logic [31:0] rdat,
        output int          low,
        output int          acc,
        output int          sel_cnt,
        output int          resp_cnt,
        output logic [3:0]  sel_or,
        output logic [3:0]  first_sel,
        output logic [31:0] paddr_s,
        output logic [31:0] pwdata_s,
        output logic        pwrite_s,
        output logic [31:0] hrdata_s
    );
        int tgt;
        bit done;
        bit seen;
        logic [3:0] tmp;
        tgt = int'(addr[13:12]);
        low = 0; acc = 0; sel_cnt = 0; resp_cnt = 0;
        sel_or = '0; first_sel = '0; paddr_s = '0; pwdata_s = '0; pwrite_s = 1'b0; hrdata_s = '0;
        done = 1'b0; seen = 1'b0;
        if (!b2b) begin
            Htrans = 2'b00;
            @(negedge Hclk);
        end
        Hwrite = wr; Haddr = addr; Htrans = 2'b10; Hreadyin = 1'b1; Hwdata = $urandom;
        for (int s = 0; s < 4; s++) Prdata[s*32 +: 32] = $urandom;
        Prdata[tgt*32 +: 32] = rdat;
        tmp = 4'($urandom); tmp[tgt] = serr; Pslverr = tmp;
        tmp = 4'($urandom); tmp[tgt] = 1'b0; Pready = tmp;
        @(negedge Hclk);
        Htrans = 2'b00; Haddr = $urandom; Hwrite = 1'($urandom); Hwdata = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c == 0) first_sel = Pselx;
            if (Pselx != 4'b0) begin
                sel_cnt++;
                sel_or = sel_or | Pselx;
                if (!seen) begin
                    seen = 1'b1; paddr_s = Paddr; pwdata_s = Pwdata; pwrite_s = Pwrite;
                end
            end
            if (Hresp) resp_cnt++;
            if (Hreadyout) begin
                done = 1'b1;
                hrdata_s = Hrdata;
            end else begin
                low++;
                tmp = 4'($urandom);
                if (Penable) begin
                    acc++;
                    tmp[tgt] = (acc > nwait);
                end else begin
                    tmp[tgt] = 1'b0;
                end
                Pready = tmp;
                @(negedge Hclk);
            end
        end
    endtask

    task automatic test_reset();
        Hreset = 1'b1; Hwrite = 0; Hreadyin = 1; Htrans = 0; Haddr = 0; Hwdata = 0;
        Prdata = '0; Pready = '0; Pslverr = '0;
        model_hrdata = '0;
        repeat (2) @(negedge Hclk);
        checks++;
        if ({Hreadyout, Hresp} !== 2'b10) begin
            errors++; $display("FAIL reset_hready_hresp: got %b want 10", {Hreadyout, Hresp});
        end
        checks++;
        if ({Pselx, Penable, Pwrite} !== 6'b0) begin
            errors++; $display("FAIL reset_apb_ctrl: got %b want 000000", {Pselx, Penable, Pwrite});
        end
        checks++;
        if (Hrdata !== 32'h0) begin
            errors++; $display("FAIL reset_hrdata: got %h want 00000000", Hrdata);
        end
        checks++;
        if ({Paddr, Pwdata} !== 64'h0) begin
            errors++; $display("FAIL reset_paddr_pwdata: got %h want 0", {Paddr, Pwdata});
        end
        Hreset = 1'b0;
        @(negedge Hclk);
    endtask

    task automatic test_write_default();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        run_xfer(0, 1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 32'h0, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        checks++; if (low !== 3) begin errors++; $display("FAIL wr_wait_states: got %0d want 3", low); end
        checks++; if (so !== 4'b0010) begin errors++; $display("FAIL wr_pselx: got %b want 0010", so); end
        checks++; if (sc !== 2) begin errors++; $display("FAIL wr_psel_cycles: got %0d want 2", sc); end
        checks++; if (acc !== 1) begin errors++; $display("FAIL wr_access_cycles: got %0d want 1", acc); end
        checks++; if (pa !== 32'h0000_1004) begin errors++; $display("FAIL wr_paddr: got %h want 00001004", pa); end
        checks++; if (pw !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_pwdata: got %h want deadbeef", pw); end
        checks++; if (pwr !== 1'b1) begin errors++; $display("FAIL wr_pwrite: got %b want 1", pwr); end
        checks++; if (rc !== 0) begin errors++; $display("FAIL wr_hresp: got %0d error cycles want 0", rc); end
        checks++; if (hr !== 32'h0) begin errors++; $display("FAIL wr_hrdata_kept: got %h want 0", hr); end
    endtask

    task automatic test_read_wait();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        run_xfer(0, 0, 32'h0000_3010, 32'h0, 2, 0, 32'hA5A5_0003, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        model_hrdata = 32'hA5A5_0003;
        checks++; if (low !== 4) begin errors++; $display("FAIL rd_wait_states: got %0d want 4", low); end
        checks++; if (acc !== 3) begin errors++; $display("FAIL rd_access_cycles: got %0d want 3", acc); end
        checks++; if (so !== 4'b1000) begin errors++; $display("FAIL rd_pselx: got %b want 1000", so); end
        checks++; if (hr !== 32'hA5A5_0003) begin errors++; $display("FAIL rd_hrdata: got %h want a5a50003", hr); end
        checks++; if (pwr !== 1'b0) begin errors++; $display("FAIL rd_pwrite: got %b want 0", pwr); end
    endtask

    task automatic test_slverr();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        run_xfer(0, 0, 32'h0000_0020, 32'h0, 0, 1, 32'h1111_2222, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        checks++; if (rc !== 2) begin errors++; $display("FAIL slverr_hresp_cycles: got %0d want 2", rc); end
        checks++; if (low !== 3) begin errors++; $display("FAIL slverr_wait_states: got %0d want 3", low); end
        checks++; if (hr !== 32'hA5A5_0003) begin errors++; $display("FAIL slverr_hrdata_kept: got %h want a5a50003", hr); end
        checks++; if (so !== 4'b0001) begin errors++; $display("FAIL slverr_pselx: got %b want 0001", so); end
    endtask

    task automatic test_unmapped();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        run_xfer(0, 1, 32'h0001_0000, 32'h5555_AAAA, 0, 0, 32'h0, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        checks++; if (sc !== 0) begin errors++; $display("FAIL unmapped_pselx: got %0d select cycles want 0", sc); end
        checks++; if (low !== 1) begin errors++; $display("FAIL unmapped_wait_states: got %0d want 1", low); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL unmapped_hresp_cycles: got %0d want 2", rc); end
        checks++; if (hr !== 32'hA5A5_0003) begin errors++; $display("FAIL unmapped_hrdata_kept: got %h want a5a50003", hr); end
    endtask

    task automatic test_timeout();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        run_xfer(0, 0, 32'h0000_2000, 32'h0, 1000, 0, 32'h7777_7777, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        checks++; if (acc !== TMO) begin errors++; $display("FAIL timeout_access_cycles: got %0d want %0d", acc, TMO); end
        checks++; if (sc !== TMO + 1) begin errors++; $display("FAIL timeout_psel_drop: got %0d select cycles want %0d", sc, TMO + 1); end
        checks++; if (low !== TMO + 2) begin errors++; $display("FAIL timeout_wait_states: got %0d want %0d", low, TMO + 2); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL timeout_hresp_cycles: got %0d want 2", rc); end
    endtask

    task automatic test_back_to_back();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        run_xfer(0, 0, 32'h0000_1100, 32'h0, 0, 0, 32'hCAFE_0001, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        checks++; if (hr !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_first_hrdata: got %h want cafe0001", hr); end
        run_xfer(1, 0, 32'h0000_2200, 32'h0, 0, 0, 32'hCAFE_0002, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        model_hrdata = 32'hCAFE_0002;
        checks++; if (fs !== 4'b0100) begin errors++; $display("FAIL b2b_setup_next_cycle: got %b want 0100", fs); end
        checks++; if (low !== 2) begin errors++; $display("FAIL b2b_wait_states: got %0d want 2", low); end
        checks++; if (hr !== 32'hCAFE_0002) begin errors++; $display("FAIL b2b_second_hrdata: got %h want cafe0002", hr); end
        checks++; if (pa !== 32'h0000_2200) begin errors++; $display("FAIL b2b_paddr: got %h want 00002200", pa); end
    endtask

    task automatic test_reset_mid();
        int n; int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        Htrans = 2'b00;
        @(negedge Hclk);
        Hwrite = 0; Haddr = 32'h0000_2000; Htrans = 2'b10; Hreadyin = 1; Pready = 4'b0000; Pslverr = 4'b0000;
        @(negedge Hclk);
        Htrans = 2'b00;
        n = 0;
        while (!Penable && n < 10) begin
            @(negedge Hclk);
            n++;
        end
        checks++; if (Penable !== 1'b1) begin errors++; $display("FAIL midrst_reach_access: got penable %b want 1", Penable); end
        #2 Hreset = 1'b1;
        #1;
        checks++;
        if ({Pselx, Penable, Hreadyout} !== 6'b000001) begin
            errors++; $display("FAIL midrst_async_outputs: got %b want 000001", {Pselx, Penable, Hreadyout});
        end
        checks++; if (Hrdata !== 32'h0) begin errors++; $display("FAIL midrst_hrdata: got %h want 0", Hrdata); end
        @(negedge Hclk);
        Hreset = 1'b0;
        model_hrdata = '0;
        run_xfer(0, 1, 32'h0000_1008, 32'h1234_5678, 0, 0, 32'h0, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);
        checks++; if (low !== 3) begin errors++; $display("FAIL midrst_wr_wait_states: got %0d want 3", low); end
        checks++; if (pw !== 32'h1234_5678) begin errors++; $display("FAIL midrst_wr_pwdata: got %h want 12345678", pw); end
        checks++; if (so !== 4'b0010) begin errors++; $display("FAIL midrst_wr_pselx: got %b want 0010", so); end
        checks++; if (rc !== 0) begin errors++; $display("FAIL midrst_wr_hresp: got %0d want 0", rc); end
    endtask

    // Transfer-level model: outcome follows from address window, slave wait count, slave error and timeout.
    task automatic test_random();
        int low, acc, sc, rc; logic [3:0] so, fs; logic [31:0] pa, pw, hr; logic pwr;
        bit wr, serr, mapped, eerr, b2b, prev_ok;
        logic [31:0] addr, wdata, rdat;
        logic [3:0] esel;
        int nwait, eacc, elow, esc;
        prev_ok = 1'b0;
        for (int it = 0; it < 30; it++) begin
            wr    = 1'($urandom);
            addr  = ($urandom_range(0, 5) == 0) ? ($urandom | 32'h0000_4000) : ($urandom & 32'h0000_3FFC);
            nwait = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 4);
            serr  = ($urandom_range(0, 5) == 0);
            wdata = $urandom;
            rdat  = $urandom;
            b2b   = prev_ok && 1'($urandom);

            mapped = (addr >> 14) == 0;
            esel   = mapped ? 4'(1 << (addr >> 12)) : 4'b0;
            if (!mapped) begin
                eacc = 0; eerr = 1'b1;
            end else if (nwait >= TMO) begin
                eacc = TMO; eerr = 1'b1;
            end else begin
                eacc = nwait + 1; eerr = serr;
            end
            elow = (mapped ? (wr ? 2 : 1) + eacc : 0) + (eerr ? 1 : 0);
            esc  = mapped ? eacc + 1 : 0;
            if (mapped && !wr && !eerr) model_hrdata = rdat;

            run_xfer(b2b, wr, addr, wdata, nwait, serr, rdat, low, acc, sc, rc, so, fs, pa, pw, pwr, hr);

            checks++; if (low !== elow) begin errors++; $display("FAIL rnd%0d_wait_states: got %0d want %0d", it, low, elow); end
            checks++; if (acc !== eacc) begin errors++; $display("FAIL rnd%0d_access_cycles: got %0d want %0d", it, acc, eacc); end
            checks++; if (so !== esel) begin errors++; $display("FAIL rnd%0d_pselx: got %b want %b", it, so, esel); end
            checks++; if (sc !== esc) begin errors++; $display("FAIL rnd%0d_psel_cycles: got %0d want %0d", it, sc, esc); end
            checks++; if (rc !== (eerr ? 2 : 0)) begin errors++; $display("FAIL rnd%0d_hresp_cycles: got %0d want %0d", it, rc, eerr ? 2 : 0); end
            checks++; if (hr !== model_hrdata) begin errors++; $display("FAIL rnd%0d_hrdata: got %h want %h", it, hr, model_hrdata); end
            if (mapped) begin
                checks++;
                if ({pa, pwr} !== {addr, wr}) begin
                    errors++; $display("FAIL rnd%0d_paddr_pwrite: got %h/%b want %h/%b", it, pa, pwr, addr, wr);
                end
                if (wr) begin
                    checks++; if (pw !== wdata) begin errors++; $display("FAIL rnd%0d_pwdata: got %h want %h", it, pw, wdata); end
                end
            end
            prev_ok = !eerr;
        end
    endtask

    initial begin
        test_reset();
        test_write_default();
        test_read_wait();
        test_slverr();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        Htrans = 2'b00;
        repeat (2) @(negedge Hclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_param.md
Name: ahb_apb_bridge_param

Overview:
Parametrised AHB-Lite to APB bridge. It replaces the fixed single-slave Bridge_Top with configurable address/data width and NUM_SLAVES decoded APB slave ports. It adds PREADY wait-state support, PSLVERR propagation as a two-cycle AHB ERROR response, a decode-error path and an optional APB timeout. It sits between the AHB-Lite master (BFM in the bench) and the APB peripheral cluster.

Parameters:
ADDR_W, 32, AHB/APB address width
DATA_W, 32, AHB/APB data width
NUM_SLAVES, 4, number of APB slaves; IDX_W = max(1, $clog2(NUM_SLAVES))
SLV_LSB, 12, LSB of the slave-index field in Haddr
TIMEOUT, 0, max ACCESS cycles with Pready low before abort; 0 disables

Ports:
Hclk  in  1  clock
Hreset  in  1  asynchronous, active-high reset
Hwrite  in  1  AHB write (address phase)
Hreadyin  in  1  AHB HREADY from bus
Htrans  in  2  AHB transfer type
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data (data phase)
Hrdata  out  DATA_W  AHB read data
Hresp  out  1  0=OKAY, 1=ERROR
Hreadyout  out  1  bridge HREADY
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Pwrite  out  1  APB write
Pselx  out  NUM_SLAVES  one-hot APB select
Penable  out  1  APB enable
Prdata  in  NUM_SLAVES*DATA_W  per-slave read data, slave i at [i*DATA_W +: DATA_W]
Pready  in  NUM_SLAVES  per-slave ready
Pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async, Hreset=1): state IDLE; Hreadyout=1, Hresp=0, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, timeout counter=0. This applies mid-transfer: Pselx/Penable drop immediately and the transfer is lost.
- Valid transfer: Hreadyin && Htrans[1] (NONSEQ/SEQ) sampled in IDLE or DONE. IDLE/BUSY are ignored.
- Decode: idx = Haddr[SLV_LSB +: IDX_W]. Unmapped if Haddr[ADDR_W-1 : SLV_LSB+IDX_W] != 0 or idx >= NUM_SLAVES.
- On a valid transfer: latch Haddr, Hwrite, idx.
- States (all outputs registered, driven by state):
  - IDLE: Hreadyout=1. Valid transfer: unmapped -> ERR1; read -> SETUP; write -> WDATA.
  - WDATA: Hreadyout=0. Capture Hwdata into Pwdata -> SETUP.
  - SETUP: Pselx[idx]=1, Penable=0, Paddr/Pwrite valid, Hreadyout=0 -> ACCESS.
  - ACCESS: Pselx[idx]=1, Penable=1, Hreadyout=0. Wait while Pready[idx]=0.
    - Pready[idx]=1 and Pslverr[idx]=1 -> ERR1.
    - Pready[idx]=1, no error -> DONE; read captures Prdata slice into Hrdata.
    - TIMEOUT!=0 and counter reaches TIMEOUT -> ERR1 (Pselx/Penable drop).
  - DONE: Hreadyout=1, Hresp=0, Hrdata held. A new valid transfer is accepted as in IDLE; otherwise -> IDLE.
  - ERR1: Hresp=1, Hreadyout=0 -> ERR2.
  - ERR2: Hresp=1, Hreadyout=1 -> IDLE. Transfers presented in ERR2 are ignored (master cancels per AHB-Lite).
- Latency, zero APB wait: read has 2 AHB wait states (Hreadyout low 2 cycles); write has 3. Each Pready-low cycle adds 1.
- Timeout counter clears on entering ACCESS and increments each ACCESS cycle with Pready[idx]=0.
- Hrdata updates only on a successful read; writes and errors leave it unchanged.
- Pwdata/Paddr hold their last values when idle.
- Pselx is never multi-hot. Pready/Pslverr of unselected slaves are ignored.

Decomposition:
- Package ahb_apb_pkg: htrans_t enum (IDLE/BUSY/NONSEQ/SEQ), bridge_state_t enum (IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2), HRESP_OKAY/HRESP_ERROR constants.
- Sub-module ahb_apb_decoder: combinational Haddr -> idx, one-hot select, unmapped flag.
- FSM, datapath registers and timeout counter live in the top module.

Test Plan:
- Defaults. Write Haddr=0x0000_1004, Hwdata=0xDEADBEEF, Pready=4'b1111 -> Pselx=4'b0010 for 2 cycles (Penable=1 in 2nd), Paddr=0x1004, Pwdata=0xDEADBEEF, Pwrite=1, Hreadyout low 3 cycles, Hresp=0.
- Read Haddr=0x0000_3010, slave3 Prdata=0xA5A5_0003, Pready[3] low 2 ACCESS cycles -> Hreadyout low 4 cycles, Hrdata=0xA5A5_0003 in DONE.
- Read slave0 with Pready[0]=1, Pslverr[0]=1 -> Hresp=1 for 2 cycles, Hreadyout 0 then 1, Hrdata unchanged.
- Write Haddr=0x0001_0000 (unmapped) -> Pselx stays 0, ERR1/ERR2 two-cycle ERROR response.
- TIMEOUT=8, Pready held 0 -> exactly 8 ACCESS cycles, then Pselx=0/Penable=0 and ERROR response. Separately, back-to-back NONSEQ reads issued in DONE -> second SETUP the cycle after DONE.
- Hreset asserted during ACCESS -> Pselx=0, Penable=0, Hreadyout=1 in the same cycle (async). After release, the next write completes normally.
